// File: rtl/alarm_ringer_if.sv
// Signal bundle between the time/alarm stage, the user buttons and the alarm ringer.
interface alarm_ringer_if;
    logic sec_tick;
    logic z;
    logic alarm_en;
    logic adjust;
    logic stop;
    logic snooze;
    logic buzzer;
    logic led;
    logic ringing;
    logic snoozed;

    modport master (
        output sec_tick, z, alarm_en, adjust, stop, snooze,
        input  buzzer, led, ringing, snoozed
    );

    modport slave (
        input  sec_tick, z, alarm_en, adjust, stop, snooze,
        output buzzer, led, ringing, snoozed
    );
endinterface

// File: rtl/alarm_ringer.sv
// Alarm-event sequencer: rings on a fresh time==alarm match, supports snooze/stop,
// times out, and drives the buzzer plus a 1 Hz blinking LED.
module alarm_ringer #(
    parameter int unsigned RING_SECS   = 60,
    parameter int unsigned SNOOZE_SECS = 300,
    parameter int unsigned MAX_SNOOZE  = 3
) (
    input  logic          funct_clk,
    input  logic          rst,
    alarm_ringer_if.slave bus
);
    localparam int unsigned RING_W  = $clog2(RING_SECS + 1);
    localparam int unsigned SLEEP_W = $clog2(SNOOZE_SECS + 1);
    localparam int unsigned SNZ_W   = $clog2(MAX_SNOOZE + 1);

    localparam logic [RING_W-1:0]  RING_LAST  = RING_W'(RING_SECS - 1);
    localparam logic [SLEEP_W-1:0] SLEEP_LAST = SLEEP_W'(SNOOZE_SECS - 1);
    localparam logic [SNZ_W-1:0]   SNZ_MAX    = SNZ_W'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } state_e;

    state_e             state_q;
    logic               z_q;
    logic [RING_W-1:0]  ring_cnt_q;
    logic [SLEEP_W-1:0] sleep_cnt_q;
    logic [SNZ_W-1:0]   snooze_cnt_q;
    logic               buzzer_q;
    logic               led_q;
    logic               ringing_q;
    logic               snoozed_q;
    logic               trig;
    logic               force_idle;

    // Only a rising edge of the match flag starts an alarm event.
    assign trig       = bus.z & ~z_q;
    assign force_idle = ~bus.alarm_en | bus.adjust;

    assign bus.buzzer  = buzzer_q;
    assign bus.led     = led_q;
    assign bus.ringing = ringing_q;
    assign bus.snoozed = snoozed_q;

    always_ff @(posedge funct_clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            z_q          <= 1'b0;
            ring_cnt_q   <= '0;
            sleep_cnt_q  <= '0;
            snooze_cnt_q <= '0;
            buzzer_q     <= 1'b0;
            led_q        <= 1'b0;
            ringing_q    <= 1'b0;
            snoozed_q    <= 1'b0;
        end else begin
            z_q <= bus.z;
            if (force_idle ||
                (state_q != IDLE && bus.stop) ||
                (state_q == RINGING && !bus.stop &&
                 !(bus.snooze && snooze_cnt_q < SNZ_MAX) &&
                 bus.sec_tick && ring_cnt_q == RING_LAST)) begin
                // Disarm, adjust, stop and ring timeout all land in a cleared IDLE.
                state_q      <= IDLE;
                ring_cnt_q   <= '0;
                sleep_cnt_q  <= '0;
                snooze_cnt_q <= '0;
                buzzer_q     <= 1'b0;
                led_q        <= 1'b0;
                ringing_q    <= 1'b0;
                snoozed_q    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (trig) begin
                            state_q      <= RINGING;
                            ring_cnt_q   <= '0;
                            snooze_cnt_q <= '0;
                            buzzer_q     <= 1'b1;
                            led_q        <= 1'b1;
                            ringing_q    <= 1'b1;
                        end
                    end
                    RINGING: begin
                        if (bus.snooze && snooze_cnt_q < SNZ_MAX) begin
                            state_q      <= SNOOZE;
                            snooze_cnt_q <= snooze_cnt_q + SNZ_W'(1);
                            sleep_cnt_q  <= '0;
                            buzzer_q     <= 1'b0;
                            led_q        <= 1'b0;
                            ringing_q    <= 1'b0;
                            snoozed_q    <= 1'b1;
                        end else if (bus.sec_tick) begin
                            ring_cnt_q <= ring_cnt_q + RING_W'(1);
                            led_q      <= ~led_q;
                            buzzer_q   <= ~led_q;
                        end
                    end
                    SNOOZE: begin
                        if (bus.sec_tick) begin
                            if (sleep_cnt_q == SLEEP_LAST) begin
                                state_q     <= RINGING;
                                ring_cnt_q  <= '0;
                                sleep_cnt_q <= '0;
                                buzzer_q    <= 1'b1;
                                led_q       <= 1'b1;
                                ringing_q   <= 1'b1;
                                snoozed_q   <= 1'b0;
                            end else begin
                                sleep_cnt_q <= sleep_cnt_q + SLEEP_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_alarm_ringer.sv
// Self-checking bench for alarm_ringer: per-cycle vector table fed through a
// scoreboard queue, plus a hand-written async-reset / held-match sequence.
module tb_alarm_ringer;
    localparam logic [3:0] IDL  = 4'b0000; // {buzzer, led, ringing, snoozed}
    localparam logic [3:0] RON  = 4'b1110;
    localparam logic [3:0] ROFF = 4'b0010;
    localparam logic [3:0] SNZ  = 4'b0001;

    typedef struct {
        string      name;
        logic       tk, zz, en, adj, stp, snz;
        int         n;
        logic [3:0] exp;
    } vec_t;

    typedef struct {
        string      name;
        logic [3:0] exp;
    } sb_t;

    logic funct_clk = 1'b0;
    logic rst       = 1'b1;
    int   checks    = 0;
    int   errors    = 0;

    vec_t vecs[$];
    sb_t  sb[$];

    alarm_ringer_if bus ();

    alarm_ringer #(
        .RING_SECS  (5),
        .SNOOZE_SECS(3),
        .MAX_SNOOZE (2)
    ) dut (
        .funct_clk(funct_clk),
        .rst      (rst),
        .bus      (bus.slave)
    );

    always #5 funct_clk = ~funct_clk;

    logic [3:0] outs;
    assign outs = {bus.buzzer, bus.led, bus.ringing, bus.snoozed};

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%b exp=%b (buzzer,led,ringing,snoozed) t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic void add(input string nm, input logic tk, input logic zz, input logic en,
                                input logic adj, input logic stp, input logic snz,
                                input int n, input logic [3:0] e);
        vec_t v;
        v.name = nm; v.tk = tk; v.zz = zz; v.en = en; v.adj = adj;
        v.stp = stp; v.snz = snz; v.n = n; v.exp = e;
        vecs.push_back(v);
    endfunction

    // One sec_tick followed by the nine quiet cycles of the same second.
    function automatic void tick(input string nm, input logic zz, input logic [3:0] e);
        add(nm, 1'b1, zz, 1'b1, 1'b0, 1'b0, 1'b0, 1, e);
        add({nm, "_gap"}, 1'b0, zz, 1'b1, 1'b0, 1'b0, 1'b0, 9, e);
    endfunction

    // Scoreboard consumer: one expected record per clock edge.
    initial begin
        sb_t s;
        forever begin
            @(posedge funct_clk);
            #1;
            if (sb.size() > 0) begin
                s = sb.pop_front();
                chk(s.name, outs, s.exp);
            end
        end
    end

    task automatic run_vectors();
        sb_t s;
        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                @(negedge funct_clk);
                bus.sec_tick = vecs[i].tk;
                bus.z        = vecs[i].zz;
                bus.alarm_en = vecs[i].en;
                bus.adjust   = vecs[i].adj;
                bus.stop     = vecs[i].stp;
                bus.snooze   = vecs[i].snz;
                s.name = vecs[i].name;
                s.exp  = vecs[i].exp;
                sb.push_back(s);
            end
        end
        @(negedge funct_clk);
        bus.sec_tick = 1'b0; bus.stop = 1'b0; bus.snooze = 1'b0;
        @(posedge funct_clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain act=%0d exp=0 entries left", sb.size());
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  entries;
        logic prev;

        bus.sec_tick = 1'b0; bus.z = 1'b0; bus.alarm_en = 1'b0;
        bus.adjust = 1'b0; bus.stop = 1'b0; bus.snooze = 1'b0;
        #12;
        chk("reset_state", outs, IDL);
        @(negedge funct_clk);
        rst = 1'b0;

        // Plain ring with LED blink and timeout; held match must not re-ring.
        add("t2_idle", 0, 0, 1, 0, 0, 0, 3, IDL);
        add("t2_trig", 0, 1, 1, 0, 0, 0, 1, RON);
        add("t2_hold", 0, 1, 1, 0, 0, 0, 4, RON);
        tick("t2_tk1", 1, ROFF);
        tick("t2_tk2", 1, RON);
        tick("t2_tk3", 1, ROFF);
        tick("t2_tk4", 1, RON);
        tick("t2_tk5_timeout", 1, IDL);
        add("t2_zhigh", 0, 1, 1, 0, 0, 0, 20, IDL);
        // Snooze, ignored snooze while sleeping, re-ring after three ticks.
        add("t3_zlow", 0, 0, 1, 0, 0, 0, 2, IDL);
        add("t3_trig", 0, 1, 1, 0, 0, 0, 1, RON);
        add("t3_hold", 0, 1, 1, 0, 0, 0, 3, RON);
        tick("t3_tk1", 1, ROFF);
        add("t3_snooze", 0, 1, 1, 0, 0, 1, 1, SNZ);
        add("t3_snz_hold", 0, 1, 1, 0, 0, 0, 3, SNZ);
        tick("t3_sl1", 1, SNZ);
        add("t3_snz_ign", 0, 1, 1, 0, 0, 1, 1, SNZ);
        tick("t3_sl2", 1, SNZ);
        tick("t3_rering", 1, RON);
        // Second snooze uses the last credit; third is ignored; ring count restarted.
        tick("t4_tk_pre", 1, ROFF);
        add("t4_snooze2", 0, 1, 1, 0, 0, 1, 1, SNZ);
        tick("t4_sl1", 1, SNZ);
        tick("t4_sl2", 1, SNZ);
        tick("t4_rering", 1, RON);
        add("t4_snz_max", 0, 1, 1, 0, 0, 1, 1, RON);
        add("t4_snz_max_hold", 0, 1, 1, 0, 0, 0, 2, RON);
        tick("t4_tk1", 1, ROFF);
        tick("t4_tk2", 1, RON);
        tick("t4_tk3", 1, ROFF);
        tick("t4_tk4", 1, RON);
        add("t4_stop", 0, 1, 1, 0, 1, 0, 1, IDL);
        add("t4_stop_hold", 0, 1, 1, 0, 0, 0, 2, IDL);
        // Stop beats snooze in the same cycle.
        add("t5_zlow", 0, 0, 1, 0, 0, 0, 2, IDL);
        add("t5_trig", 0, 1, 1, 0, 0, 0, 1, RON);
        add("t5_hold", 0, 1, 1, 0, 0, 0, 2, RON);
        add("t5_stop_snz", 0, 1, 1, 0, 1, 1, 1, IDL);
        add("t5_after", 0, 1, 1, 0, 0, 0, 3, IDL);
        // Adjust / disarm blocking and forcing IDLE; stop from SNOOZE.
        add("t6_zlow", 0, 0, 1, 0, 0, 0, 2, IDL);
        add("t6_adj_rise", 0, 1, 1, 1, 0, 0, 3, IDL);
        add("t6_adj_off", 0, 1, 1, 0, 0, 0, 3, IDL);
        add("t6_zlow2", 0, 0, 1, 0, 0, 0, 2, IDL);
        add("t6_trig", 0, 1, 1, 0, 0, 0, 1, RON);
        add("t6_snooze", 0, 1, 1, 0, 0, 1, 1, SNZ);
        add("t6_snz_hold", 0, 1, 1, 0, 0, 0, 2, SNZ);
        add("t6_adj_snz", 0, 1, 1, 1, 0, 0, 1, IDL);
        add("t6_adj_hold", 0, 1, 1, 1, 0, 0, 2, IDL);
        add("t6_zlow3", 0, 0, 1, 0, 0, 0, 2, IDL);
        add("t6_en_off", 0, 1, 0, 0, 0, 0, 3, IDL);
        add("t6_en_on", 0, 1, 1, 0, 0, 0, 3, IDL);
        add("t6_zlow4", 0, 0, 1, 0, 0, 0, 2, IDL);
        add("t6_trig2", 0, 1, 1, 0, 0, 0, 1, RON);
        add("t6_snooze2", 0, 1, 1, 0, 0, 1, 1, SNZ);
        add("t6_stop_snz", 0, 1, 1, 0, 1, 0, 1, IDL);
        add("t6_end", 0, 0, 1, 0, 0, 0, 2, IDL);
        run_vectors();

        // Async reset mid-ring, then a held match rings exactly once.
        @(negedge funct_clk);
        bus.z = 1'b0; bus.alarm_en = 1'b1; bus.adjust = 1'b0;
        repeat (2) @(negedge funct_clk);
        bus.z = 1'b1;
        @(posedge funct_clk);
        #1;
        chk("t1_ring_before_rst", outs, RON);
        #3;
        rst = 1'b1;
        #1;
        chk("t1_async_rst", outs, IDL);
        @(negedge funct_clk);
        @(negedge funct_clk);
        rst = 1'b0;
        entries = 0;
        prev = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge funct_clk);
            bus.sec_tick = (i % 10 == 9);
            @(posedge funct_clk);
            #1;
            if (bus.ringing && !prev) entries++;
            prev = bus.ringing;
        end
        bus.sec_tick = 1'b0;
        checks++;
        if (entries != 1) begin
            errors++;
            $display("FAIL t1_ring_entries act=%0d exp=1", entries);
        end
        chk("t1_final_idle", outs, IDL);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
